// File: rtl/line_buffer_3row_if.sv
// ---------------------------------------------------------------------------
// line_buffer_3row_if
// Pixel stream bundle between a raster pixel source and line_buffer_3row.
//   pixel_in/pixel_valid/sof : raster-order input pixel, qualifier, frame start
//   pixel_ready              : block accepts pixel_in this cycle
//   pixel_out_row_1..3       : one column of the 3-line window (oldest first)
//   shift_en                 : new column strobe for a downstream 3x3 shifter
//   window_valid             : downstream window holds a full 3x3 neighbourhood
//   frame_done               : pulse with the column of the last frame pixel
// Modports: master = pixel source / consumer side, slave = line buffer.
// ---------------------------------------------------------------------------
interface line_buffer_3row_if;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       sof;
  logic       pixel_ready;
  logic [7:0] pixel_out_row_1;
  logic [7:0] pixel_out_row_2;
  logic [7:0] pixel_out_row_3;
  logic       shift_en;
  logic       window_valid;
  logic       frame_done;

  modport master (
    output pixel_in, pixel_valid, sof,
    input  pixel_ready, pixel_out_row_1, pixel_out_row_2, pixel_out_row_3,
    input  shift_en, window_valid, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, sof,
    output pixel_ready, pixel_out_row_1, pixel_out_row_2, pixel_out_row_3,
    output shift_en, window_valid, frame_done
  );
endinterface

// File: rtl/line_buffer_3row.sv
// ---------------------------------------------------------------------------
// line_buffer_3row
// Buffers the two previous image lines so that every accepted pixel is
// emitted one cycle later together with the pixels of the same column from
// the two lines above it, forming one column of a 3x3 window.
// Ports:
//   clock : single clock, all state updates on its rising edge
//   reset : synchronous, active-high
//   bus   : line_buffer_3row_if.slave (pixel input, ready, row outputs,
//           shift_en / window_valid / frame_done strobes)
// Parameters: IMG_WIDTH (>=3) pixels per line, IMG_HEIGHT (>=3) lines.
// ---------------------------------------------------------------------------
module line_buffer_3row #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                clock,
  input  logic                reset,
  line_buffer_3row_if.slave   bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic          w_ready;
  logic          w_in_frame;
  logic          w_xfer;
  logic          w_accept;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_eol;
  logic          w_eof;

  // Line memories: no reset, stale contents are masked by row position.
  logic [7:0] lb_old [0:IMG_WIDTH-1];
  logic [7:0] lb_mid [0:IMG_WIDTH-1];
  logic [7:0] r_rd_old;
  logic [7:0] r_rd_mid;

  logic [7:0] r_row3;
  logic       r_use_old;
  logic       r_use_mid;
  logic       r_shift_en;
  logic       r_window_valid;
  logic       r_frame_done;

  assign w_xfer = bus.pixel_valid & w_ready;
  // In IDLE only an sof pixel starts a frame; anything else is dropped.
  assign w_accept = w_xfer & (bus.sof | w_in_frame);

  // An sof pixel is always (0,0), even if it interrupts a frame.
  assign w_col = bus.sof ? '0 : r_col;
  assign w_row = bus.sof ? '0 : r_row;
  assign w_eol = (w_col == COL_LAST);
  assign w_eof = w_eol & (w_row == ROW_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && bus.sof) w_state_next = S_FILL;
      end
      S_FILL: begin
        if (w_xfer) begin
          if (bus.sof)                           w_state_next = S_FILL;
          else if (w_eol && w_row == RW'(1))     w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_xfer) begin
          if (bus.sof)   w_state_next = S_FILL;
          else if (w_eof) w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;  // S_DONE lasts exactly one cycle
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_in_frame = (r_state == S_FILL) || (r_state == S_STREAM);
    // Gated by reset so ready is low for the whole reset assertion.
    w_ready    = !reset && (r_state != S_DONE);
  end

  // ---------------- Position counters ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_eof) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_eol) begin
        r_col <= '0;
        r_row <= w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // ---------------- Line memories, read-before-write ----------------
  always_ff @(posedge clock) begin
    if (w_accept) begin
      lb_old[w_col] <= lb_mid[w_col];
      lb_mid[w_col] <= bus.pixel_in;
      r_rd_old      <= lb_old[w_col];
      r_rd_mid      <= lb_mid[w_col];
    end
  end

  // ---------------- Output column and strobes ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_row3         <= 8'h00;
      r_use_old      <= 1'b0;
      r_use_mid      <= 1'b0;
      r_shift_en     <= 1'b0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else if (w_accept) begin
      r_row3         <= bus.pixel_in;
      r_use_mid      <= (w_row >= RW'(1));
      r_use_old      <= (w_row >= RW'(2));
      r_shift_en     <= 1'b1;
      r_window_valid <= (w_row >= RW'(2)) && (w_col >= CW'(2));
      r_frame_done   <= w_eof;
    end else begin
      // Row outputs hold; strobes drop.
      r_shift_en     <= 1'b0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end
  end

  assign bus.pixel_ready     = w_ready;
  assign bus.pixel_out_row_3 = r_row3;
  assign bus.pixel_out_row_2 = r_use_mid ? r_rd_mid : 8'h00;
  assign bus.pixel_out_row_1 = r_use_old ? r_rd_old : 8'h00;
  assign bus.shift_en        = r_shift_en;
  assign bus.window_valid    = r_window_valid;
  assign bus.frame_done      = r_frame_done;

endmodule

// File: tb/tb_line_buffer_3row.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_3row
// Directed bench for line_buffer_3row with a 4x4 image, pixel = 16*r+c.
// Each accepted pixel is checked one cycle later against the expected
// column (rows masked above the frame top), window_valid and frame_done.
// ---------------------------------------------------------------------------
module tb_line_buffer_3row;
  localparam int W = 4;
  localparam int H = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  line_buffer_3row_if bus ();

  line_buffer_3row #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sh_cnt, wv_cnt, fd_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Send one pixel, then check the column emitted in the following cycle.
  task automatic send_pixel(input int r, input int c, input bit sof_b);
    logic [7:0] pix, e2, e1;
    pix = 8'(16 * r + c);
    e2  = (r >= 1) ? 8'(16 * (r - 1) + c) : 8'h00;
    e1  = (r >= 2) ? 8'(16 * (r - 2) + c) : 8'h00;
    bus.pixel_in    = pix;
    bus.pixel_valid = 1'b1;
    bus.sof         = sof_b;
    check_eq("ready", bus.pixel_ready, 1);
    tick();
    bus.pixel_valid = 1'b0;
    bus.sof         = 1'b0;
    $display("xfer (%0d,%0d) in=%02h rows=%02h/%02h/%02h sh=%0b wv=%0b fd=%0b",
             r, c, pix, bus.pixel_out_row_1, bus.pixel_out_row_2,
             bus.pixel_out_row_3, bus.shift_en, bus.window_valid, bus.frame_done);
    check_eq("shift_en", bus.shift_en, 1);
    check_eq("row_3", bus.pixel_out_row_3, pix);
    check_eq("row_2", bus.pixel_out_row_2, e2);
    check_eq("row_1", bus.pixel_out_row_1, e1);
    check_eq("window_valid", bus.window_valid, (r >= 2 && c >= 2) ? 1 : 0);
    check_eq("frame_done", bus.frame_done, (r == H - 1 && c == W - 1) ? 1 : 0);
    sh_cnt += int'(bus.shift_en);
    wv_cnt += int'(bus.window_valid);
    fd_cnt += int'(bus.frame_done);
  endtask

  // Cycle with no accepted pixel: strobes low, row outputs hold.
  task automatic quiet_cycle(input logic valid_b, input logic [7:0] pix);
    logic [7:0] p1, p2, p3;
    p1 = bus.pixel_out_row_1;
    p2 = bus.pixel_out_row_2;
    p3 = bus.pixel_out_row_3;
    bus.pixel_in    = pix;
    bus.pixel_valid = valid_b;
    bus.sof         = 1'b0;
    tick();
    bus.pixel_valid = 1'b0;
    $display("quiet valid=%0b in=%02h rows=%02h/%02h/%02h sh=%0b",
             valid_b, pix, bus.pixel_out_row_1, bus.pixel_out_row_2,
             bus.pixel_out_row_3, bus.shift_en);
    check_eq("quiet_shift_en", bus.shift_en, 0);
    check_eq("quiet_window_valid", bus.window_valid, 0);
    check_eq("quiet_frame_done", bus.frame_done, 0);
    check_eq("hold_row_3", bus.pixel_out_row_3, p3);
    check_eq("hold_row_2", bus.pixel_out_row_2, p2);
    check_eq("hold_row_1", bus.pixel_out_row_1, p1);
  endtask

  // Send raster pixels (0,0)..(last_r,last_c); full frames also check DONE.
  task automatic send_frame(input bit toggle, input int last_r, input int last_c);
    int n;
    n = last_r * W + last_c;
    sh_cnt = 0;
    wv_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i <= n; i++) begin
      send_pixel(i / W, i % W, i == 0);
      if (toggle && i != n) quiet_cycle(1'b0, 8'h5A);
    end
    if (last_r == H - 1 && last_c == W - 1) begin
      check_eq("done_ready_low", bus.pixel_ready, 0);
      check_eq("shift_en_count", sh_cnt, W * H);
      check_eq("window_valid_count", wv_cnt, (W - 2) * (H - 2));
      check_eq("frame_done_count", fd_cnt, 1);
      tick();
      check_eq("idle_ready_high", bus.pixel_ready, 1);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #0;
    check_eq("rst_ready", bus.pixel_ready, 0);
    tick();
    check_eq("rst_ready_held", bus.pixel_ready, 0);
    check_eq("rst_row_1", bus.pixel_out_row_1, 0);
    check_eq("rst_row_2", bus.pixel_out_row_2, 0);
    check_eq("rst_row_3", bus.pixel_out_row_3, 0);
    check_eq("rst_shift_en", bus.shift_en, 0);
    check_eq("rst_window_valid", bus.window_valid, 0);
    check_eq("rst_frame_done", bus.frame_done, 0);
    reset = 1'b0;
    #0;
    check_eq("post_rst_ready", bus.pixel_ready, 1);
  endtask

  initial begin
    bus.pixel_in    = 8'h00;
    bus.pixel_valid = 1'b0;
    bus.sof         = 1'b0;
    tick();
    pulse_reset();

    // Continuous full frame.
    send_frame(1'b0, H - 1, W - 1);

    // Valid toggling every cycle.
    send_frame(1'b1, H - 1, W - 1);

    // Non-sof pixels in IDLE are discarded.
    for (int i = 0; i < 3; i++) quiet_cycle(1'b1, 8'hAA);
    send_frame(1'b0, H - 1, W - 1);

    // Reset after pixel (2,1), then a fresh frame.
    send_frame(1'b0, 2, 1);
    pulse_reset();
    send_frame(1'b0, H - 1, W - 1);

    // sof mid-frame restarts the frame.
    send_frame(1'b0, 1, 2);
    send_frame(1'b0, H - 1, W - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_3row.md
LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line, SHALL be at least 3.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame, SHALL be at least 3.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pixel_in  input  8  raster-order pixel data.
REQ-006 pixel_valid  input  1  pixel_in is valid this cycle.
REQ-007 sof  input  1  start of frame; qualified by pixel_valid; marks pixel (0,0).
REQ-008 pixel_ready  output  1  block accepts pixel_in this cycle; transfer = pixel_valid & pixel_ready.
REQ-009 pixel_out_row_1  output  8  pixel from line r-2, same column (oldest line).
REQ-010 pixel_out_row_2  output  8  pixel from line r-1, same column.
REQ-011 pixel_out_row_3  output  8  pixel from line r, i.e. the accepted pixel.
REQ-012 shift_en  output  1  one-cycle strobe; the three row outputs are a new column for a downstream 3x3 window shifter.
REQ-013 window_valid  output  1  with shift_en: downstream window holds a complete 3x3 neighbourhood.
REQ-014 frame_done  output  1  one-cycle pulse with shift_en of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

Function
REQ-015 States SHALL be IDLE, FILL (lines 0-1), STREAM (lines 2..IMG_HEIGHT-1), DONE.
REQ-016 IDLE: pixel_ready=1; a transfer with sof=1 is pixel (0,0) -> FILL; a transfer with sof=0 is discarded with no output.
REQ-017 FILL/STREAM: pixel_ready=1; each transfer advances the column counter c, which wraps at IMG_WIDTH-1 to 0 and increments the line counter r.
REQ-018 FILL -> STREAM when the transfer at (1, IMG_WIDTH-1) is accepted.
REQ-019 STREAM -> DONE when the transfer at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
REQ-020 DONE: pixel_ready=0 for exactly one cycle, then -> IDLE.
REQ-021 Two line memories of IMG_WIDTH x 8 bits, lb_old and lb_mid, SHALL be indexed by c.
REQ-022 On a transfer at column c, lb_old[c] <= lb_mid[c] and lb_mid[c] <= pixel_in.
REQ-023 Latency: the outputs for a transfer in cycle N SHALL appear, with shift_en=1, in cycle N+1 only.
REQ-024 Row outputs: row_3=pixel_in; row_2=lb_mid[c], or 0 if r<1; row_1=lb_old[c], or 0 if r<2.
REQ-025 window_valid=1 with shift_en iff r>=2 and c>=2; otherwise 0.
REQ-026 If no transfer occurs in cycle N, shift_en, window_valid and frame_done SHALL be 0 in cycle N+1 and the row outputs SHALL hold.
REQ-027 A transfer with sof=1 in FILL or STREAM SHALL restart the frame: that pixel is (0,0), state -> FILL, and the prior partial frame is abandoned.
REQ-028 The line memories SHALL need no reset; REQ-024 masks stale contents.

Reset
REQ-029 While reset=1: state=IDLE; r=0; c=0; pixel_ready=0; all row outputs 0; shift_en=0; window_valid=0; frame_done=0.
REQ-030 In the first cycle after reset deasserts, pixel_ready SHALL be 1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL begin only on sof.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*r+c)
REQ-032 Full 4x4 frame, continuous valid -> shift_en x16; window_valid x4, at (2,2),(2,3),(3,2),(3,3); frame_done once; pixel_ready=0 for one cycle afterwards.
REQ-033 Pixel (2,2) accepted -> next cycle row_1=0x02, row_2=0x12, row_3=0x22, window_valid=1.
REQ-034 Pixel (1,0) accepted -> next cycle row_1=0x00 (masked), row_2=0x00, row_3=0x10, window_valid=0.
REQ-035 pixel_valid toggled 1/0 every cycle through the frame -> identical output sequence to REQ-032; shift_en never in consecutive cycles.
REQ-036 Pixels sent in IDLE without sof, then sof at (0,0) -> no shift_en until the sof pixel; the sof pixel outputs row_3=0x00.
REQ-037 reset pulsed after pixel (2,1), then a new frame is sent -> pixel (1,0) of the new frame yields row_1=0 and row_2=0x00 per REQ-024; the first window_valid is at the new (2,2).
